// File: rtl/tron_pkg.sv
// -----------------------------------------------------------------------------
// tron_pkg
// Shared types and helpers for the light-cycle engine.
//   dir_t    : heading of a cycle (UP, DOWN, LEFT, RIGHT)
//   state_t  : engine FSM states
//   DIR_OH_* : one-hot request encodings, bit order {right,left,down,up}
//   PALETTE  : owner id -> 24-bit {red,green,blue}
//   reverse(), dir_decode(), is_onehot4(), dir_ok() : steering helpers
// -----------------------------------------------------------------------------
package tron_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_PLACE     = 4'd2,
        S_WAIT_TICK = 4'd3,
        S_READ      = 4'd4,
        S_CHECK     = 4'd5,
        S_WRITE     = 4'd6,
        S_NEXT      = 4'd7,
        S_EVAL      = 4'd8,
        S_OVER      = 4'd9
    } state_t;

    localparam logic [3:0] DIR_OH_UP    = 4'b0001;
    localparam logic [3:0] DIR_OH_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_OH_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_OH_RIGHT = 4'b1000;

    // 0 black, 1 blue, 2 red, 3 green, 4 yellow, 5 cyan, 6 magenta, 7 white
    localparam logic [23:0] PALETTE [0:7] = '{
        24'h000000, 24'h0000ff, 24'hff0000, 24'h00ff00,
        24'hffff00, 24'h00ffff, 24'hff00ff, 24'hffffff
    };

    function automatic dir_t reverse(input dir_t d);
        dir_t r;
        unique case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            default: r = LEFT;
        endcase
        return r;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for a one-hot request; anything else maps to UP.
    function automatic dir_t dir_decode(input logic [3:0] req);
        dir_t d;
        unique case (req)
            DIR_OH_DOWN:  d = DOWN;
            DIR_OH_LEFT:  d = LEFT;
            DIR_OH_RIGHT: d = RIGHT;
            default:      d = UP;
        endcase
        return d;
    endfunction

    // A request is taken only if it is one-hot and not a U-turn.
    function automatic logic dir_ok(input logic [3:0] req, input dir_t cur);
        return is_onehot4(req) && (dir_decode(req) != reverse(cur));
    endfunction

endpackage

// File: rtl/tron_trail_engine_if.sv
// -----------------------------------------------------------------------------
// tron_trail_engine_if
// Bundle between the VGA/game front end (master) and the engine (slave).
//   start      : one-cycle pulse, clears grid and begins a round
//   row, col   : current scan position (10 bits each)
//   dir_req    : per player one-hot {right,left,down,up}, player i at [4i+3:4i]
//   red/green/blue : registered pixel colour
//   busy, alive, crash, game_over, winner : round status
//   state_dbg  : engine FSM state for observation
// Signalling: there is no valid/ready pair. start is a single-cycle strobe
// sampled on every clock; row/col/dir_req are level inputs sampled every
// clock; all outputs are levels except crash, which pulses for one clock.
// -----------------------------------------------------------------------------
interface tron_trail_engine_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int ID_W        = $clog2(NUM_PLAYERS + 1)
);
    import tron_pkg::*;

    logic                     start;
    logic [9:0]               row;
    logic [9:0]               col;
    logic [4*NUM_PLAYERS-1:0] dir_req;
    logic [7:0]               red;
    logic [7:0]               green;
    logic [7:0]               blue;
    logic                     busy;
    logic [NUM_PLAYERS-1:0]   alive;
    logic [NUM_PLAYERS-1:0]   crash;
    logic                     game_over;
    logic [ID_W-1:0]          winner;
    state_t                   state_dbg;

    modport master (
        output start, row, col, dir_req,
        input  red, green, blue, busy, alive, crash, game_over, winner, state_dbg
    );

    modport slave (
        input  start, row, col, dir_req,
        output red, green, blue, busy, alive, crash, game_over, winner, state_dbg
    );
endinterface

// File: rtl/trail_mem.sv
// -----------------------------------------------------------------------------
// trail_mem
// Per-pixel ownership RAM, true dual port, 1-cycle read latency on both ports.
//   clock            : clock
//   a_addr/a_we/a_wdata/a_rdata : engine read/write port
//   b_addr/b_rdata   : display read-only port
// Contents are not reset; the engine clears them at the start of a round.
// -----------------------------------------------------------------------------
module trail_mem #(
    parameter int DEPTH = 480000,
    parameter int WIDTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [AW-1:0]    a_addr,
    input  logic             a_we,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/tron_trail_engine.sv
// -----------------------------------------------------------------------------
// tron_trail_engine
// N-player light-cycle engine: ownership grid, one-pixel-per-frame movement,
// collision detection, round status and pixel colour for the VGA generator.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : start, row, col, dir_req in; red/green/blue, busy, alive,
//                  crash, game_over, winner, state_dbg out
// Build option: define TRAIL_WRAP_EN to make screen edges wrap instead of
// acting as walls.
// -----------------------------------------------------------------------------
module tron_trail_engine
    import tron_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int H_RES       = 800,
    parameter int V_RES       = 600,
    parameter int ID_W        = $clog2(NUM_PLAYERS + 1)
) (
    input  logic clock,
    input  logic reset,
    tron_trail_engine_if.slave bus
);
    localparam int              DEPTH     = H_RES * V_RES;
    localparam int              AW        = $clog2(DEPTH);
    localparam int              PW        = $clog2(NUM_PLAYERS);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0]   LAST_P    = PW'(NUM_PLAYERS - 1);
    localparam logic [9:0]      X_MAX     = 10'(H_RES - 1);
    localparam logic [9:0]      Y_MAX     = 10'(V_RES - 1);
    localparam logic [9:0]      Y_START   = 10'(V_RES / 2);

    function automatic logic [AW-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        return AW'(y) * AW'(H_RES) + AW'(x);
    endfunction

    state_t                 state, state_nx;
    logic [AW-1:0]          clr_addr;
    logic [PW-1:0]          pidx, pidx_inc;
    logic [9:0]             head_x [NUM_PLAYERS];
    logic [9:0]             head_y [NUM_PLAYERS];
    dir_t                   heading [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] alive_r, crash_vec;
    logic                   game_over_r;
    logic [ID_W-1:0]        winner_r;
    logic [9:0]             nx_r, ny_r, nx_c, ny_c, cx, cy;
    logic                   wall_r, wall_c, hit, tick;
    dir_t                   cd;
    logic [ID_W-1:0]        live_cnt, surv_id, pid;
    logic [AW-1:0]          mem_addr, b_addr;
    logic                   mem_we;
    logic [ID_W-1:0]        mem_wdata, a_rdata, b_rdata;
    logic                   in_active, act_d;
    logic [23:0]            rgb_r;
    logic [9:0]             start_x [NUM_PLAYERS];

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_start
        assign start_x[g] = 10'((g + 1) * H_RES / (NUM_PLAYERS + 1));
    end

    assign tick     = (int'(bus.row) == V_RES - 1) && (int'(bus.col) == H_RES - 1);
    assign pidx_inc = pidx + 1'b1;
    assign pid      = ID_W'(pidx) + 1'b1;
    assign hit      = wall_r || (a_rdata != '0);

    // Candidate next head position for the player being processed.
    always_comb begin
        cx     = head_x[pidx];
        cy     = head_y[pidx];
        cd     = heading[pidx];
        nx_c   = cx;
        ny_c   = cy;
        wall_c = 1'b0;
        unique case (cd)
            UP: begin
                if (cy == 10'd0) begin
`ifdef TRAIL_WRAP_EN
                    ny_c = Y_MAX;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    ny_c = cy - 1'b1;
                end
            end
            DOWN: begin
                if (cy == Y_MAX) begin
`ifdef TRAIL_WRAP_EN
                    ny_c = 10'd0;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    ny_c = cy + 1'b1;
                end
            end
            LEFT: begin
                if (cx == 10'd0) begin
`ifdef TRAIL_WRAP_EN
                    nx_c = X_MAX;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    nx_c = cx - 1'b1;
                end
            end
            default: begin
                if (cx == X_MAX) begin
`ifdef TRAIL_WRAP_EN
                    nx_c = 10'd0;
`else
                    wall_c = 1'b1;
`endif
                end else begin
                    nx_c = cx + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        live_cnt = '0;
        surv_id  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_r[i]) begin
                live_cnt = live_cnt + 1'b1;
                surv_id  = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and port-A control. start always wins and restarts the round.
    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_IDLE: state_nx = S_IDLE;
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr;
                if (clr_addr == LAST_ADDR) state_nx = S_PLACE;
            end
            S_PLACE: begin
                mem_we    = 1'b1;
                mem_addr  = cell_addr(start_x[pidx], Y_START);
                mem_wdata = pid;
                if (pidx == LAST_P) state_nx = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (tick) state_nx = alive_r[0] ? S_READ : S_NEXT;
            end
            S_READ: begin
                mem_addr = cell_addr(nx_c, ny_c);
                state_nx = S_CHECK;
            end
            S_CHECK: state_nx = S_WRITE;
            S_WRITE: begin
                // alive_r still set here means CHECK found the cell free.
                mem_we    = alive_r[pidx];
                mem_addr  = cell_addr(nx_r, ny_r);
                mem_wdata = pid;
                state_nx  = S_NEXT;
            end
            S_NEXT: begin
                if (pidx == LAST_P) state_nx = S_EVAL;
                else state_nx = alive_r[pidx_inc] ? S_READ : S_NEXT;
            end
            S_EVAL: state_nx = (live_cnt < ID_W'(2)) ? S_OVER : S_WAIT_TICK;
            S_OVER: state_nx = S_OVER;
            default: state_nx = S_IDLE;
        endcase
        if (bus.start) state_nx = S_CLEAR;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_addr    <= '0;
            pidx        <= '0;
            alive_r     <= '0;
            game_over_r <= 1'b0;
            winner_r    <= '0;
            nx_r        <= '0;
            ny_r        <= '0;
            wall_r      <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                head_x[i]  <= '0;
                head_y[i]  <= '0;
                heading[i] <= UP;
            end
        end else if (bus.start) begin
            clr_addr    <= '0;
            pidx        <= '0;
            alive_r     <= '0;
            game_over_r <= 1'b0;
            winner_r    <= '0;
        end else begin
            unique case (state)
                S_CLEAR: clr_addr <= clr_addr + 1'b1;
                S_PLACE: begin
                    head_x[pidx]  <= start_x[pidx];
                    head_y[pidx]  <= Y_START;
                    heading[pidx] <= pidx[0] ? DOWN : UP;
                    alive_r[pidx] <= 1'b1;
                    pidx          <= (pidx == LAST_P) ? '0 : pidx_inc;
                end
                S_WAIT_TICK: begin
                    if (tick) begin
                        pidx <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (dir_ok(bus.dir_req[4*i +: 4], heading[i])) begin
                                heading[i] <= dir_decode(bus.dir_req[4*i +: 4]);
                            end
                        end
                    end
                end
                S_READ: begin
                    nx_r   <= nx_c;
                    ny_r   <= ny_c;
                    wall_r <= wall_c;
                end
                S_CHECK: begin
                    if (hit) alive_r[pidx] <= 1'b0;
                end
                S_WRITE: begin
                    if (alive_r[pidx]) begin
                        head_x[pidx] <= nx_r;
                        head_y[pidx] <= ny_r;
                    end
                end
                S_NEXT: begin
                    if (pidx != LAST_P) pidx <= pidx_inc;
                end
                S_EVAL: begin
                    if (live_cnt == '0) begin
                        game_over_r <= 1'b1;
                        winner_r    <= '0;
                    end else if (live_cnt == ID_W'(1)) begin
                        game_over_r <= 1'b1;
                        winner_r    <= surv_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Crash is reported combinationally during the CHECK cycle of the victim.
    always_comb begin
        crash_vec = '0;
        if (state == S_CHECK) crash_vec[pidx] = hit;
    end

    trail_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ID_W),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .a_addr  (mem_addr),
        .a_we    (mem_we),
        .a_wdata (mem_wdata),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata)
    );

    // Display pipe: address this cycle, RAM data next, colour register after.
    assign in_active = (int'(bus.row) < V_RES) && (int'(bus.col) < H_RES);
    assign b_addr    = in_active ? cell_addr(bus.col, bus.row) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_d <= 1'b0;
            rgb_r <= '0;
        end else begin
            act_d <= in_active;
            rgb_r <= act_d ? PALETTE[3'(b_rdata)] : 24'h000000;
        end
    end

    assign bus.red       = rgb_r[23:16];
    assign bus.green     = rgb_r[15:8];
    assign bus.blue      = rgb_r[7:0];
    assign bus.busy      = (state == S_CLEAR) || (state == S_PLACE);
    assign bus.alive     = alive_r;
    assign bus.crash     = crash_vec;
    assign bus.game_over = game_over_r;
    assign bus.winner    = winner_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_tron_trail_engine.sv
`timescale 1ns/1ps
module tb_tron_trail_engine;
    import tron_pkg::*;

    localparam int NP = 2;
    localparam int H  = 66;
    localparam int V  = 30;
    localparam int IDW = 2;
    // Start positions: x = (i+1)*H/(NP+1), y = V/2
    localparam int X0 = 22;
    localparam int X1 = 44;
    localparam int Y0 = 15;
    localparam logic [9:0]  IDLE_ROW = 10'(V + 3);
    localparam logic [3:0]  R_NONE  = 4'b0000;
    localparam logic [3:0]  R_DOWN  = 4'b0010;
    localparam logic [3:0]  R_LEFT  = 4'b0100;
    localparam logic [3:0]  R_RIGHT = 4'b1000;
    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_BLUE  = 24'h0000ff;
    localparam logic [23:0] C_RED   = 24'hff0000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tron_trail_engine_if #(.NUM_PLAYERS(NP), .ID_W(IDW)) bus ();

    tron_trail_engine #(
        .NUM_PLAYERS (NP),
        .H_RES       (H),
        .V_RES       (V),
        .ID_W        (IDW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q [$];
    int crash0_cnt = 0;
    int crash1_cnt = 0;
    int c0, c1;

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.crash[0]) crash0_cnt++;
            if (bus.crash[1]) crash1_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("busy_released", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_tick(input logic [3:0] req0, input logic [3:0] req1);
        @(negedge clock);
        bus.dir_req = {req1, req0};
        bus.row     = 10'(V - 1);
        bus.col     = 10'(H - 1);
        @(negedge clock);
        bus.dir_req = '0;
        bus.row     = IDLE_ROW;
        bus.col     = 10'd0;
        repeat (12) @(negedge clock);
    endtask

    task automatic read_pixel(input string tag, input int x, input int y, input logic [23:0] exp);
        logic [23:0] e;
        @(negedge clock);
        bus.row = 10'(y);
        bus.col = 10'(x);
        exp_q.push_back(exp);
        repeat (2) @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check(tag, {8'd0, bus.red, bus.green, bus.blue}, {8'd0, e});
        bus.row = IDLE_ROW;
        bus.col = 10'd0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_alive"}, 32'(bus.alive), 32'd0);
        check({tag, "_crash"}, 32'(bus.crash), 32'd0);
        check({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
        check({tag, "_winner"}, 32'(bus.winner), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rgb"}, {8'd0, bus.red, bus.green, bus.blue}, 32'd0);
        check({tag, "_state"}, 32'(bus.state_dbg), 32'(S_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.start   = 1'b0;
        bus.row     = IDLE_ROW;
        bus.col     = 10'd0;
        bus.dir_req = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_state", 32'(bus.state_dbg), 32'(S_IDLE));

        // Round 1: placement, steering rules, wall (or wrap) at the top edge.
        do_start();
        wait_ready();
        check("r1_alive", 32'(bus.alive), 32'd3);
        check("r1_game_over", 32'(bus.game_over), 32'd0);
        check("r1_state", 32'(bus.state_dbg), 32'(S_WAIT_TICK));
        read_pixel("r1_p0_start", X0, Y0, C_BLUE);
        read_pixel("r1_p1_start", X1, Y0, C_RED);
        read_pixel("r1_empty", 0, 0, C_BLACK);
        read_pixel("r1_outside", H + 2, 3, C_BLACK);

        do_tick(R_DOWN, R_RIGHT);              // reverse request for p0 is ignored
        read_pixel("t1_p0_up", X0, Y0 - 1, C_BLUE);
        read_pixel("t1_p0_not_down", X0, Y0 + 1, C_BLACK);
        read_pixel("t1_p1_right", X1 + 1, Y0, C_RED);

        do_tick(R_LEFT | R_RIGHT, R_NONE);     // multi-hot request is ignored
        read_pixel("t2_p0_up", X0, Y0 - 2, C_BLUE);
        read_pixel("t2_p0_not_left", X0 - 1, Y0 - 1, C_BLACK);
        read_pixel("t2_p0_not_right", X0 + 1, Y0 - 1, C_BLACK);
        read_pixel("t2_p1_right", X1 + 2, Y0, C_RED);

        for (int k = 3; k <= Y0; k++) begin
            do_tick(R_NONE, R_NONE);
            read_pixel("tk_p0_head", X0, Y0 - k, C_BLUE);
        end
        check("before_edge_alive", 32'(bus.alive), 32'd3);
        check("before_edge_game_over", 32'(bus.game_over), 32'd0);

        c0 = crash0_cnt;
        c1 = crash1_cnt;
        do_tick(R_NONE, R_NONE);
`ifdef TRAIL_WRAP_EN
        check("wrap_crash0", 32'(crash0_cnt - c0), 32'd0);
        check("wrap_alive", 32'(bus.alive), 32'd3);
        check("wrap_game_over", 32'(bus.game_over), 32'd0);
        read_pixel("wrap_p0_bottom", X0, V - 1, C_BLUE);
`else
        check("wall_crash0_pulses", 32'(crash0_cnt - c0), 32'd1);
        check("wall_crash1_pulses", 32'(crash1_cnt - c1), 32'd0);
        check("wall_alive", 32'(bus.alive), 32'd2);
        check("wall_game_over", 32'(bus.game_over), 32'd1);
        check("wall_winner", 32'(bus.winner), 32'd2);
        check("wall_state", 32'(bus.state_dbg), 32'(S_OVER));
        do_tick(R_NONE, R_NONE);
        check("over_ignores_tick", 32'(bus.alive), 32'd2);
        check("over_holds_winner", 32'(bus.winner), 32'd2);
`endif

        // Round 2: head-on into the same cell, lower index wins.
        do_start();
        wait_ready();
        check("r2_alive", 32'(bus.alive), 32'd3);
        check("r2_game_over", 32'(bus.game_over), 32'd0);
        check("r2_winner", 32'(bus.winner), 32'd0);
        read_pixel("r2_old_trail_cleared", X0, Y0 - 1, C_BLACK);
        c0 = crash0_cnt;
        c1 = crash1_cnt;
        do_tick(R_RIGHT, R_LEFT);
        for (int k = 2; k <= 10; k++) do_tick(R_NONE, R_NONE);
        check("r2_pre_alive", 32'(bus.alive), 32'd3);
        read_pixel("r2_p0_t10", X0 + 10, Y0, C_BLUE);
        read_pixel("r2_p1_t10", X1 - 10, Y0, C_RED);
        do_tick(R_NONE, R_NONE);
        check("headon_crash1_pulses", 32'(crash1_cnt - c1), 32'd1);
        check("headon_crash0_pulses", 32'(crash0_cnt - c0), 32'd0);
        check("headon_alive", 32'(bus.alive), 32'd1);
        check("headon_game_over", 32'(bus.game_over), 32'd1);
        check("headon_winner", 32'(bus.winner), 32'd1);
        read_pixel("headon_cell_owner", X0 + 11, Y0, C_BLUE);
        read_pixel("headon_p1_frozen", X1 - 10, Y0, C_RED);

        // Round 3: abort mid-round with start, then reset during CLEAR.
        do_start();
        wait_ready();
        do_tick(R_NONE, R_NONE);
        do_tick(R_NONE, R_NONE);
        check("r3_running", 32'(bus.state_dbg), 32'(S_WAIT_TICK));
        do_start();
        check("abort_state", 32'(bus.state_dbg), 32'(S_CLEAR));
        repeat (50) @(negedge clock);
        check("abort_still_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("mid_clear_reset");
        reset = 1'b0;
        @(negedge clock);
        check("after_reset_idle", 32'(bus.state_dbg), 32'(S_IDLE));
        repeat (5) @(negedge clock);
        check("idle_stays", 32'(bus.state_dbg), 32'(S_IDLE));

        do_start();
        wait_ready();
        check("r4_alive", 32'(bus.alive), 32'd3);
        read_pixel("r4_clean_abort_trail", X0, Y0 - 2, C_BLACK);
        read_pixel("r4_clean_headon", X0 + 11, Y0, C_BLACK);
        read_pixel("r4_p0_start", X0, Y0, C_BLUE);
        read_pixel("r4_p1_start", X1, Y0, C_RED);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tron_trail_engine.md
# tron_trail_engine

Parametrised N-player light-cycle engine for the VGA Tron build. Holds a per-pixel ownership grid, advances every live player one pixel per frame, detects collisions against trails, walls and other heads, and outputs round status. Drives the pixel colour for the VGA timing generator and supersedes the single-player blue-trace drawer.

## Interface
- NUM_PLAYERS, 2: players, 2..7
- H_RES, 800: active columns
- V_RES, 600: active rows
- ID_W, $clog2(NUM_PLAYERS+1): owner-id width; 0 = empty cell
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high; one clock, all state on `clock`
- start  in  1  one-cycle pulse: clear grid, place players, begin round
- row, col  in  10 each  current scan position from VGA timing
- dir_req  in  4*NUM_PLAYERS  per player one-hot {right,left,down,up}, player i at [4i+3:4i]
- red, green, blue  out  8 each  pixel colour, registered
- busy  out  1  high in CLEAR/PLACE
- alive  out  NUM_PLAYERS  live mask
- crash  out  NUM_PLAYERS  one-cycle pulse per player on death
- game_over  out  1  level, round finished
- winner  out  ID_W  surviving player id+1; 0 = draw or no round

## Operation
- Reset: state IDLE; alive=0, crash=0, game_over=0, winner=0, busy=0, RGB=0. Grid RAM is not cleared by reset.
- Tick = (row==V_RES-1 && col==H_RES-1), one cycle per frame.
- States: IDLE -start-> CLEAR (write 0 to every address, H_RES*V_RES cycles) -> PLACE (one write per player) -> WAIT_TICK -tick-> per player i=0..N-1: READ -> CHECK -> WRITE -> NEXT; after the last player -> EVAL -> WAIT_TICK or OVER. OVER -start-> CLEAR.
- start in any state except IDLE/OVER also restarts at CLEAR (abort).
- PLACE: player i at x=(i+1)*H_RES/(NUM_PLAYERS+1), y=V_RES/2; even i heads up, odd i heads down; owner id i+1 is written; all alive.
- Direction latch at tick: exactly one bit set and not the reverse of the current heading -> new heading; zero, multi-hot or reverse -> keep heading.
- Dead players skip READ/CHECK/WRITE (NEXT only).
- Next position: ±1 in x or y. Stepping past 0 or H_RES-1/V_RES-1 is a wall crash.
- CHECK: cell nonzero -> crash; else WRITE stores id i+1 and updates the head.
- Head-on into the same cell in one tick: lower index claims it first; higher index crashes on READ. Deterministic, by design.
- Crash: alive[i] cleared, crash[i] pulses in the CHECK cycle, head frozen.
- EVAL: live count 0 -> game_over=1, winner=0; live count 1 -> game_over=1, winner=id of survivor; else continue.
- Display: port B address row*H_RES+col; owner -> palette (0 black, 1 blue, 2 red, 3 green, 4 yellow, 5 cyan, 6 magenta, 7 white); outside the active area -> black.

## Timing
- RAM: true dual port; port A engine R/W, port B display read-only; 1-cycle read latency.
- RGB valid 2 cycles after row/col (RAM + output register); the VGA timing generator compensates.
- Per-tick update: 4 cycles per player + 1 EVAL, well inside blanking.
- A tick arriving in CLEAR/PLACE or mid-update is ignored; no queued moves.
- Address arithmetic is zero-extended to $clog2(H_RES*V_RES) bits; no truncation.

## Configuration
- TRAIL_WRAP_EN defined: edges wrap (x=0 left -> H_RES-1, y=V_RES-1 down -> 0, etc.); only trail occupancy kills.
- Undefined: edges are walls and crash as above.

## Structure
- Package tron_pkg: dir_t enum (UP, DOWN, LEFT, RIGHT), state_t enum, palette constant array, dir one-hot encodings, reverse() function.
- Sub-module trail_mem: parameterised dual-port RAM (depth H_RES*V_RES, width ID_W) with port A read/write and port B read.

## Test plan
- Reset, start, wait out busy -> alive=2'b11; pixel (266,300) reads blue, (533,300) reads red; game_over=0.
- No input for 300 ticks, player 0 heading up -> wall at y=0 after tick 301: crash[0] pulse, alive=2'b10, game_over=1, winner=2.
- TRAIL_WRAP_EN defined, same stimulus -> no crash; head wraps to y=599 at tick 301.
- Player 0 requests down while heading up -> ignored; head y decrements by 1 per tick.
- Steer both heads onto the same cell on the same tick -> player 1 crashes, player 0 survives, winner=1.
- Assert start mid-round, then reset during CLEAR -> returns to IDLE; all outputs 0; next start yields a clean grid.
